// File: rtl/data_memory_access_unit.sv
// Load/store front end for a word-addressed data memory: byte/half/word
// accesses, misaligned splitting into two word cycles, registered response.
module data_memory_access_unit #(
  parameter int DATA_BITS        = 13,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_address,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_error,
  output logic [31:0]          rsp_rdata,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);
  localparam int   IDX_BITS = DATA_BITS - 2;
  localparam logic SPLIT_OK = (ALLOW_MISALIGNED != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SECOND = 2'd1, RESP = 2'd2} state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // pair = {hi[23:0], lo}: only these bytes can reach the result for any offset
  function automatic logic [31:0] extend_load(input logic [55:0] pair, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    case (off)
      2'd0:    sh = pair[31:0];
      2'd1:    sh = pair[39:8];
      2'd2:    sh = pair[47:16];
      default: sh = pair[55:24];
    endcase
    case (size)
      2'd0:    r = {{24{sh[7] & ~uns}}, sh[7:0]};
      2'd1:    r = {{16{sh[15] & ~uns}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic                  write_q, write_d;
  logic                  uns_q, uns_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic [1:0]  req_off_s;
  logic [2:0]  req_n_s;
  logic        split_s;
  logic        err_s;
  logic [1:0]  lane_off_s;
  logic [3:0]  lane_mask_s;
  logic [31:0] lane_wdata_s;
  logic [7:0]  lane_be_s;
  logic [63:0] lane_data_s;

  assign req_off_s = req_address[1:0];
  assign req_n_s   = size_bytes(req_size);
  assign split_s   = ({2'b00, req_off_s} + {1'b0, req_n_s}) > 4'd4;
  assign err_s     = (req_size == 2'd3) || (|req_address[31:DATA_BITS]) ||
                     (split_s && !SPLIT_OK) || (split_s && (&req_address[DATA_BITS-1:2]));

  // Upper half of the 8-lane shift is exactly the second word's lanes
  assign lane_off_s   = (state_q == SECOND) ? off_q : req_off_s;
  assign lane_mask_s  = (state_q == SECOND) ? size_mask(size_q) : size_mask(req_size);
  assign lane_wdata_s = (state_q == SECOND) ? wdata_q : req_wdata;
  assign lane_be_s    = {4'b0000, lane_mask_s} << lane_off_s;
  assign lane_data_s  = {32'h0000_0000, lane_wdata_s} << {lane_off_s, 3'b000};

  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  // Memory drive: quiet unless an access is underway; reset suppresses a pending second write
  always_comb begin
    mem_address = {IDX_BITS{1'b0}};
    mem_byteena = 4'b0000;
    mem_data    = 32'h0000_0000;
    mem_wren    = 1'b0;
    if (!reset_n) begin
      mem_wren = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && !err_s) begin
            mem_address = req_address[DATA_BITS-1:2];
            mem_byteena = lane_be_s[3:0];
            mem_data    = lane_data_s[31:0];
            mem_wren    = req_write;
          end else begin
            mem_wren = 1'b0;
          end
        end
        SECOND: begin
          mem_address = idx_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
          mem_byteena = lane_be_s[7:4];
          mem_data    = lane_data_s[63:32];
          mem_wren    = write_q;
        end
        default: mem_wren = 1'b0;
      endcase
    end
  end

  // Next-state, capture and response computation
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    write_d     = write_q;
    uns_d       = uns_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d   = req_off_s;
          size_d  = req_size;
          idx_d   = req_address[DATA_BITS-1:2];
          wdata_d = req_wdata;
          write_d = req_write;
          uns_d   = req_unsigned;
          lo_d    = mem_q;
          if (err_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (split_s) begin
            state_d = SECOND;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_write ? 32'h0000_0000
                        : extend_load({24'h00_0000, mem_q}, req_off_s, req_size, req_unsigned);
          end
        end else begin
          state_d = IDLE;
        end
      end
      SECOND: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = write_q ? 32'h0000_0000
                    : extend_load({mem_q[23:0], lo_q}, off_q, size_q, uns_q);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      idx_q       <= {IDX_BITS{1'b0}};
      wdata_q     <= 32'h0000_0000;
      lo_q        <= 32'h0000_0000;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      write_q     <= write_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule
